// File: rtl/microwave_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : microwave_ctrl
// Description : Front-panel sequencer between the panel debouncers and the
//               countdown timer; drives magnetron, lamp, beeper and status.
// Revision    : 1.0 - initial release
// ============================================================================
module microwave_ctrl #(
    parameter int BEEP_CYCLES = 300_000_000,
    parameter int BEEP_HALF   = 50_000_000,
    parameter int ARM_TIMEOUT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_pause,
    input  logic       door_open,
    input  logic [1:0] prog_sel,
    input  logic [6:0] man_min,
    input  logic [6:0] man_sec,
    input  logic       tmr_done,
    output logic       tmr_start,
    output logic       tmr_stop,
    output logic       tmr_pause,
    output logic [6:0] tmr_min,
    output logic [6:0] tmr_sec,
    output logic       mag_en,
    output logic       lamp,
    output logic       beep,
    output logic [5:0] stat_d6
);

    localparam int c_ARM_W  = $clog2(ARM_TIMEOUT + 1);
    localparam int c_BEEP_W = $clog2(BEEP_CYCLES + 1);
    localparam int c_HALF_W = $clog2(BEEP_HALF + 1);

    localparam logic [c_ARM_W-1:0]  c_ARM_LAST  = c_ARM_W'(ARM_TIMEOUT - 1);
    localparam logic [c_ARM_W-1:0]  c_ARM_MAX   = c_ARM_W'(ARM_TIMEOUT);
    localparam logic [c_BEEP_W-1:0] c_BEEP_LAST = c_BEEP_W'(BEEP_CYCLES - 1);
    localparam logic [c_BEEP_W-1:0] c_BEEP_MAX  = c_BEEP_W'(BEEP_CYCLES);
    localparam logic [c_HALF_W-1:0] c_HALF_LAST = c_HALF_W'(BEEP_HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_RUN    = 3'd2,
        S_PAUSED = 3'd3,
        S_BEEP   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_go_start, w_go_stop, w_go_pause;
    logic [6:0]          w_sel_min, w_sel_sec;
    logic                w_sel_nz;
    logic [3:0]          w_code;
    logic [c_ARM_W-1:0]  r_arm_cnt;
    logic [c_BEEP_W-1:0] r_beep_cnt;
    logic [c_HALF_W-1:0] r_half_cnt;
    logic                r_tmr_start, r_tmr_stop, r_tmr_pause;
    logic [6:0]          r_tmr_min, r_tmr_sec;
    logic                r_mag_en, r_lamp, r_beep;
    logic [5:0]          r_stat_d6;

    always_comb begin
        w_sel_min = 7'd0;
        w_sel_sec = 7'd0;
        case (prog_sel)
            2'b00: begin
                w_sel_min = (man_min > 7'd99) ? 7'd99 : man_min;
                w_sel_sec = (man_sec > 7'd59) ? 7'd59 : man_sec;
            end
            2'b01: begin w_sel_min = 7'd2; w_sel_sec = 7'd30; end
            2'b10: begin w_sel_min = 7'd1; w_sel_sec = 7'd15; end
            default: begin w_sel_min = 7'd5; w_sel_sec = 7'd0; end
        endcase
        w_sel_nz = (w_sel_min != 7'd0) || (w_sel_sec != 7'd0);
    end

    // Branch order inside each state encodes stop > door > pause > start.
    always_comb begin
        w_state_nxt = r_state;
        w_go_start  = 1'b0;
        w_go_stop   = 1'b0;
        w_go_pause  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (btn_start && !door_open && w_sel_nz) begin
                    w_state_nxt = S_ARM;
                    w_go_start  = 1'b1;
                end
            end
            S_ARM: begin
                if (btn_stop || door_open || (tmr_done && r_arm_cnt >= c_ARM_LAST)) begin
                    w_state_nxt = S_IDLE;
                    w_go_stop   = 1'b1;
                end else if (!tmr_done) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (btn_stop) begin
                    w_state_nxt = S_IDLE;
                    w_go_stop   = 1'b1;
                end else if (door_open || btn_pause) begin
                    w_state_nxt = S_PAUSED;
                    w_go_pause  = 1'b1;
                end else if (tmr_done) begin
                    w_state_nxt = S_BEEP;
                end
            end
            S_PAUSED: begin
                if (btn_stop) begin
                    w_state_nxt = S_IDLE;
                    w_go_stop   = 1'b1;
                end else if (!door_open && (btn_start || btn_pause)) begin
                    w_state_nxt = S_RUN;
                    w_go_start  = 1'b1;
                end
            end
            S_BEEP: begin
                if (btn_stop || door_open || r_beep_cnt >= c_BEEP_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_code = 4'h0;
        if (door_open) begin
            w_code = 4'hD;
        end else begin
            case (w_state_nxt)
                S_ARM, S_RUN: w_code = 4'h1;
                S_PAUSED:     w_code = 4'h2;
                S_BEEP:       w_code = 4'h3;
                default:      w_code = 4'h0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_tmr_start <= 1'b0;
            r_tmr_stop  <= 1'b0;
            r_tmr_pause <= 1'b0;
            r_tmr_min   <= 7'd0;
            r_tmr_sec   <= 7'd0;
            r_mag_en    <= 1'b0;
            r_lamp      <= door_open;
            r_beep      <= 1'b0;
            r_stat_d6   <= 6'b10_0000;
            r_arm_cnt   <= '0;
            r_beep_cnt  <= '0;
            r_half_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_tmr_start <= w_go_start;
            r_tmr_stop  <= w_go_stop;
            r_tmr_pause <= w_go_pause;
            r_mag_en    <= (w_state_nxt == S_RUN);
            r_lamp      <= door_open || (w_state_nxt == S_ARM) || (w_state_nxt == S_RUN);
            r_stat_d6   <= {1'b1, w_code, 1'b0};

            if (r_state == S_IDLE) begin
                r_tmr_min <= w_sel_min;
                r_tmr_sec <= w_sel_sec;
            end

            if (w_state_nxt == S_ARM && r_state != S_ARM) begin
                r_arm_cnt <= '0;
            end else if (r_state == S_ARM && r_arm_cnt != c_ARM_MAX) begin
                r_arm_cnt <= r_arm_cnt + 1'b1;
            end

            // Beeper starts high on entry and flips every BEEP_HALF cycles.
            if (w_state_nxt == S_BEEP && r_state != S_BEEP) begin
                r_beep_cnt <= '0;
                r_half_cnt <= '0;
                r_beep     <= 1'b1;
            end else if (w_state_nxt == S_BEEP) begin
                if (r_beep_cnt != c_BEEP_MAX) begin
                    r_beep_cnt <= r_beep_cnt + 1'b1;
                end
                if (r_half_cnt >= c_HALF_LAST) begin
                    r_half_cnt <= '0;
                    r_beep     <= ~r_beep;
                end else begin
                    r_half_cnt <= r_half_cnt + 1'b1;
                end
            end else begin
                r_beep <= 1'b0;
            end
        end
    end

    assign tmr_start = r_tmr_start;
    assign tmr_stop  = r_tmr_stop;
    assign tmr_pause = r_tmr_pause;
    assign tmr_min   = r_tmr_min;
    assign tmr_sec   = r_tmr_sec;
    assign mag_en    = r_mag_en;
    assign lamp      = r_lamp;
    assign beep      = r_beep;
    assign stat_d6   = r_stat_d6;

endmodule
`default_nettype wire

// File: tb/tb_microwave_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_microwave_ctrl
// Description : Directed and random stimulus for microwave_ctrl, checked every
//               cycle against a mode/elapsed-time reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_microwave_ctrl;

    localparam int BC = 20;
    localparam int BH = 4;
    localparam int AT = 4;

    localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_PAUSED = 3, M_BEEP = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       btn_start, btn_stop, btn_pause, door_open;
    logic [1:0] prog_sel;
    logic [6:0] man_min, man_sec;
    logic       tmr_done;
    logic       tmr_start, tmr_stop, tmr_pause;
    logic [6:0] tmr_min, tmr_sec;
    logic       mag_en, lamp, beep;
    logic [5:0] stat_d6;

    microwave_ctrl #(.BEEP_CYCLES(BC), .BEEP_HALF(BH), .ARM_TIMEOUT(AT)) dut (
        .clock(clock), .reset(reset),
        .btn_start(btn_start), .btn_stop(btn_stop), .btn_pause(btn_pause),
        .door_open(door_open), .prog_sel(prog_sel),
        .man_min(man_min), .man_sec(man_sec), .tmr_done(tmr_done),
        .tmr_start(tmr_start), .tmr_stop(tmr_stop), .tmr_pause(tmr_pause),
        .tmr_min(tmr_min), .tmr_sec(tmr_sec),
        .mag_en(mag_en), .lamp(lamp), .beep(beep), .stat_d6(stat_d6)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: current mode and how many cycles it has already lasted.
    int   m_mode = M_IDLE;
    int   m_t    = 0;
    logic e_start, e_stop, e_pause, e_mag, e_lamp, e_beep;
    int   e_min, e_sec;
    logic [5:0] e_stat;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int clampv(input int v, input int hi);
        return (v > hi) ? hi : v;
    endfunction

    task automatic model_step();
        int smin, ssec, nxt, code;
        e_start = 1'b0; e_stop = 1'b0; e_pause = 1'b0;
        case (prog_sel)
            2'd0:    begin smin = clampv(int'(man_min), 99); ssec = clampv(int'(man_sec), 59); end
            2'd1:    begin smin = 2; ssec = 30; end
            2'd2:    begin smin = 1; ssec = 15; end
            default: begin smin = 5; ssec = 0;  end
        endcase
        if (reset) begin
            m_mode = M_IDLE; m_t = 0; e_min = 0; e_sec = 0;
            e_mag = 1'b0; e_beep = 1'b0; e_lamp = door_open; e_stat = 6'b10_0000;
            return;
        end
        nxt = m_mode;
        case (m_mode)
            M_IDLE: begin
                e_min = smin; e_sec = ssec;
                if (btn_start && !door_open && (smin * 60 + ssec) > 0) begin
                    nxt = M_ARM; e_start = 1'b1;
                end
            end
            M_ARM: begin
                if (btn_stop || door_open)   begin nxt = M_IDLE; e_stop = 1'b1; end
                else if (!tmr_done)          nxt = M_RUN;
                else if (m_t + 1 >= AT)      begin nxt = M_IDLE; e_stop = 1'b1; end
            end
            M_RUN: begin
                if (btn_stop)                    begin nxt = M_IDLE;   e_stop  = 1'b1; end
                else if (door_open || btn_pause) begin nxt = M_PAUSED; e_pause = 1'b1; end
                else if (tmr_done)               nxt = M_BEEP;
            end
            M_PAUSED: begin
                if (btn_stop) begin nxt = M_IDLE; e_stop = 1'b1; end
                else if (!door_open && (btn_start || btn_pause)) begin nxt = M_RUN; e_start = 1'b1; end
            end
            default: begin
                if (btn_stop || door_open || m_t + 1 >= BC) nxt = M_IDLE;
            end
        endcase
        m_t    = (nxt == m_mode) ? m_t + 1 : 0;
        m_mode = nxt;
        e_mag  = (m_mode == M_RUN);
        e_lamp = door_open || m_mode == M_ARM || m_mode == M_RUN;
        e_beep = (m_mode == M_BEEP) && ((m_t / BH) % 2 == 0);
        case (m_mode)
            M_ARM, M_RUN: code = 1;
            M_PAUSED:     code = 2;
            M_BEEP:       code = 3;
            default:      code = 0;
        endcase
        if (door_open) code = 13;
        e_stat = {1'b1, 4'(code), 1'b0};
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        #1;
        chk("tmr_start", {7'd0, tmr_start}, {7'd0, e_start});
        chk("tmr_stop",  {7'd0, tmr_stop},  {7'd0, e_stop});
        chk("tmr_pause", {7'd0, tmr_pause}, {7'd0, e_pause});
        chk("tmr_min",   {1'b0, tmr_min},   8'(e_min));
        chk("tmr_sec",   {1'b0, tmr_sec},   8'(e_sec));
        chk("mag_en",    {7'd0, mag_en},    {7'd0, e_mag});
        chk("lamp",      {7'd0, lamp},      {7'd0, e_lamp});
        chk("beep",      {7'd0, beep},      {7'd0, e_beep});
        chk("stat_d6",   {2'd0, stat_d6},   {2'd0, e_stat});
    endtask

    task automatic clr_btn();
        btn_start = 1'b0; btn_stop = 1'b0; btn_pause = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clr_btn(); door_open = 1'b0; prog_sel = 2'd0;
        man_min = 7'd0; man_sec = 7'd0; tmr_done = 1'b1;
        step(); step();
        chk("reset_stat", {2'd0, stat_d6}, 8'h20);
        reset = 1'b0;
        step();

        // Popcorn start, timer acknowledges, run
        prog_sel = 2'd1; btn_start = 1'b1; step(); clr_btn();
        chk("pop_pulse", {7'd0, tmr_start}, 8'd1);
        chk("pop_min", {1'b0, tmr_min}, 8'd2);
        chk("pop_sec", {1'b0, tmr_sec}, 8'd30);
        tmr_done = 1'b0; step(); step();
        chk("run_mag", {7'd0, mag_en}, 8'd1);

        // Door opens while running, then close and resume
        door_open = 1'b1; step();
        chk("door_pause", {7'd0, tmr_pause}, 8'd1);
        chk("door_stat", {2'd0, stat_d6}, 8'h3A);
        step();
        door_open = 1'b0; step();
        btn_start = 1'b1; step(); clr_btn();
        chk("resume_pulse", {7'd0, tmr_start}, 8'd1);
        step();

        // Timer finishes: beep pattern then idle
        tmr_done = 1'b1;
        repeat (23) step();
        chk("beep_off", {7'd0, beep}, 8'd0);

        // Manual 0:00 is ignored; oversize manual values clamp
        prog_sel = 2'd0; man_min = 7'd0; man_sec = 7'd0;
        btn_start = 1'b1; step(); clr_btn();
        chk("zero_nostart", {7'd0, tmr_start}, 8'd0);
        man_min = 7'd120; man_sec = 7'd75; step(); step();
        chk("clamp_min", {1'b0, tmr_min}, 8'd99);
        chk("clamp_sec", {1'b0, tmr_sec}, 8'd59);
        btn_start = 1'b1; step(); clr_btn();
        tmr_done = 1'b0; step(); step();

        // Stop and pause together: stop wins
        btn_stop = 1'b1; btn_pause = 1'b1; step(); clr_btn();
        chk("stop_wins", {6'd0, tmr_stop, tmr_pause}, 8'd2);
        tmr_done = 1'b1; step();

        // Timer never acknowledges: arm timeout
        btn_start = 1'b1; step(); clr_btn();
        repeat (6) step();

        // Reset in the middle of a run
        btn_start = 1'b1; step(); clr_btn();
        tmr_done = 1'b0; step(); step();
        reset = 1'b1; step();
        chk("rst_mag", {7'd0, mag_en}, 8'd0);
        reset = 1'b0; step();

        // Random phase with a simple timer model
        for (int i = 0; i < 4000; i++) begin
            btn_start = ($urandom % 6) == 0;
            btn_stop  = ($urandom % 25) == 0;
            btn_pause = ($urandom % 10) == 0;
            if (($urandom % 15) == 0) door_open = ~door_open;
            if (($urandom % 40) == 0) prog_sel = 2'($urandom);
            if (($urandom % 40) == 0) begin
                man_min = (($urandom % 3) == 0) ? 7'd0 : 7'($urandom);
                man_sec = (($urandom % 3) == 0) ? 7'd0 : 7'($urandom);
            end
            reset = ($urandom % 300) == 0;
            step();
            if (e_start)      tmr_done = (($urandom % 8) == 0);
            else if (e_stop)  tmr_done = 1'b1;
            else if (!tmr_done && ($urandom % 30) == 0) tmr_done = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
